// File: rtl/uartmm_fifo.sv
// -----------------------------------------------------------------------------
// uartmm_fifo -- memory-mapped UART bridge with RX/TX FIFOs.
//
// Decouples the CPU data-side bus (port B) from the byte-level UART: received
// bytes are buffered in an RX FIFO, transmit bytes are queued in a TX FIFO and
// drained by a two-state send FSM whenever the transmitter is not busy.
//
// Register window (offsets from BASE_ADDR):
//   +1 RXVALID  +2 TXREADY  +3 DATA  +4 COUNT  +5 STATUS (W1C bit4)  +6 IRQEN
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   uart_din/uart_valid received byte and its one-cycle strobe
//   uart_busy           transmitter busy
//   uart_dout/uart_wr   registered transmit byte and one-cycle strobe
//   addr_b, data_b_in,  bus address, write data, write enable (bit0 only)
//   data_b_we
//   data_b, strobe_b    combinational read data and window hit
//   irq                 registered interrupt request
//
// Build option: define UARTMM_FIFO_IRQ_EN to implement IRQEN and drive irq;
// otherwise IRQEN reads 0 and irq is tied low.
// -----------------------------------------------------------------------------
module uartmm_fifo #(
   parameter int unsigned BASE_ADDR = 65536,
   parameter int unsigned RX_DEPTH  = 16,
   parameter int unsigned TX_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  uart_din,
   input  logic        uart_valid,
   input  logic        uart_busy,
   output logic [7:0]  uart_dout,
   output logic        uart_wr,
   output logic [31:0] data_b,
   output logic        strobe_b,
   input  logic [31:0] addr_b,
   input  logic [31:0] data_b_in,
   input  logic [31:0] data_b_we,
   output logic        irq
);

   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

   localparam logic [31:0] A_RXVALID = 32'(BASE_ADDR + 1);
   localparam logic [31:0] A_TXREADY = 32'(BASE_ADDR + 2);
   localparam logic [31:0] A_DATA    = 32'(BASE_ADDR + 3);
   localparam logic [31:0] A_COUNT   = 32'(BASE_ADDR + 4);
   localparam logic [31:0] A_STATUS  = 32'(BASE_ADDR + 5);
   localparam logic [31:0] A_IRQEN   = 32'(BASE_ADDR + 6);

   typedef enum logic {S_IDLE, S_SEND} tx_state_t;

   // storage and state
   logic [7:0]     r_rx_mem [RX_DEPTH];
   logic [7:0]     r_tx_mem [TX_DEPTH];
   logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
   logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
   logic [RX_AW:0] r_rx_cnt;
   logic [TX_AW:0] r_tx_cnt;
   logic           r_rx_ovf;
   logic [7:0]     r_uart_dout;
   logic           r_uart_wr;
   tx_state_t      r_state, w_state_nxt;

   // decode and flags
   logic w_data_rd, w_data_wr, w_status_wr;
   logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic w_rx_push, w_rx_pop, w_rx_ovf_set, w_tx_push, w_tx_pop;
   logic [7:0] w_status;
   logic [1:0] w_irqen;
   logic       w_unused;

   assign w_data_rd   = (addr_b == A_DATA) && !data_b_we[0];
   assign w_data_wr   = (addr_b == A_DATA) &&  data_b_we[0];
   assign w_status_wr = (addr_b == A_STATUS) && data_b_we[0];

   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == RX_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == TX_FULL);

   // A pop at full frees the slot the incoming byte lands in, so the push is
   // accepted and overflow is only flagged when nothing leaves that cycle.
   assign w_rx_pop     = w_data_rd && !w_rx_empty;
   assign w_rx_push    = uart_valid && (!w_rx_full || w_rx_pop);
   assign w_rx_ovf_set = uart_valid && w_rx_full && !w_rx_pop;
   assign w_tx_push    = w_data_wr && !w_tx_full;

   assign w_status = {3'b000, r_rx_ovf, w_tx_empty, w_rx_full, !w_tx_full, !w_rx_empty};
   assign w_unused = ^{data_b_in[31:8], data_b_we[31:1]};

   // ---------------- RX FIFO ----------------
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= uart_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
         r_rx_ovf <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RX_AW+1)'(1);
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (RX_AW+1)'(1);
         // a fresh overflow wins over a same-cycle clear
         if (w_rx_ovf_set)                     r_rx_ovf <= 1'b1;
         else if (w_status_wr && data_b_in[4]) r_rx_ovf <= 1'b0;
      end
   end

   // ---------------- TX FIFO ----------------
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= data_b_in[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (TX_AW+1)'(1);
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (TX_AW+1)'(1);
      end
   end

   // ---------------- TX send FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_pop    = 1'b0;
      case (r_state)
         S_IDLE: if (!w_tx_empty && !uart_busy && !r_uart_wr) begin
            w_state_nxt = S_SEND;
            w_tx_pop    = 1'b1;
         end
         S_SEND: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_uart_dout <= '0;
         r_uart_wr   <= 1'b0;
      end else begin
         r_uart_wr <= w_tx_pop;
         if (w_tx_pop) r_uart_dout <= r_tx_mem[r_tx_rp];
      end
   end

   assign uart_dout = r_uart_dout;
   assign uart_wr   = r_uart_wr;

   // ---------------- interrupt ----------------
`ifdef UARTMM_FIFO_IRQ_EN
   logic [1:0] r_irqen;
   logic       r_irq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_irqen <= '0;
         r_irq   <= 1'b0;
      end else begin
         if ((addr_b == A_IRQEN) && data_b_we[0]) r_irqen <= data_b_in[1:0];
         r_irq <= (!w_rx_empty & r_irqen[0]) | (w_tx_empty & r_irqen[1]) |
                  (r_rx_ovf & r_irqen[0]);
      end
   end

   assign w_irqen = r_irqen;
   assign irq     = r_irq;
`else
   assign w_irqen = '0;
   assign irq     = 1'b0;
`endif

   // ---------------- bus read ----------------
   assign strobe_b = (addr_b >= A_RXVALID) && (addr_b <= A_IRQEN);

   always_comb begin
      data_b = '0;
      case (addr_b)
         A_RXVALID: data_b[0]    = !w_rx_empty;
         A_TXREADY: data_b[0]    = !w_tx_full;
         A_DATA:    data_b[7:0]  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
         A_COUNT:   data_b[15:0] = {8'(r_tx_cnt), 8'(r_rx_cnt)};
         A_STATUS:  data_b[7:0]  = w_status;
         A_IRQEN:   data_b[1:0]  = w_irqen;
         default:   data_b       = '0;
      endcase
   end

endmodule
